// File: rtl/flag_branch_unit.sv
// Execute-stage flag register (Z, V, N) and conditional branch resolver.
// Flags come from the ALU result and adder overflow. A branch evaluates its
// condition against the flags, taking a same-cycle flag write into account
// flag by flag. The redirect decision is registered for the fetch stage.
module flag_branch_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic [WIDTH-1:0] ex_result,
    input  logic             ex_ovfl,
    input  logic             z_en,
    input  logic             v_en,
    input  logic             n_en,
    input  logic             br_valid,
    input  logic [2:0]       br_ccc,
    input  logic [WIDTH-1:0] br_target,
    input  logic [WIDTH-1:0] pc_next,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n,
    output logic             br_resolved,
    output logic             br_taken,
    output logic [WIDTH-1:0] br_pc
);

    typedef enum logic [2:0] {
        CC_NE = 3'b000,
        CC_EQ = 3'b001,
        CC_GT = 3'b010,
        CC_LT = 3'b011,
        CC_GE = 3'b100,
        CC_LE = 3'b101,
        CC_OV = 3'b110,
        CC_UN = 3'b111
    } ccc_e;

    logic             flag_z_q, flag_v_q, flag_n_q;
    logic             flag_z_d, flag_v_d, flag_n_d;
    logic             br_resolved_q, br_resolved_d;
    logic             br_taken_q, br_taken_d;
    logic [WIDTH-1:0] br_pc_q, br_pc_d;

    logic new_z, new_n, new_v;
    logic eff_z, eff_n, eff_v;
    logic wr, br_acc, cond;

    // Flag sources, write/accept qualifiers and per-flag bypass
    always_comb begin
        new_z  = (ex_result == '0);
        new_n  = ex_result[WIDTH-1];
        new_v  = ex_ovfl;
        wr     = ex_valid & ~flush & ~stall;
        br_acc = br_valid & ~flush & ~stall;
        eff_z  = (ex_valid & z_en & ~flush) ? new_z : flag_z_q;
        eff_v  = (ex_valid & v_en & ~flush) ? new_v : flag_v_q;
        eff_n  = (ex_valid & n_en & ~flush) ? new_n : flag_n_q;
    end

    // Condition code evaluation on the effective flags
    always_comb begin
        cond = 1'b0;
        unique case (ccc_e'(br_ccc))
            CC_NE: cond = ~eff_z;
            CC_EQ: cond = eff_z;
            CC_GT: cond = ~eff_z & ~eff_n;
            CC_LT: cond = eff_n;
            CC_GE: cond = eff_z | (~eff_z & ~eff_n);
            CC_LE: cond = eff_n | eff_z;
            CC_OV: cond = eff_v;
            CC_UN: cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    // Next-state: stall holds everything, including a pending resolved pulse
    always_comb begin
        flag_z_d      = flag_z_q;
        flag_v_d      = flag_v_q;
        flag_n_d      = flag_n_q;
        br_resolved_d = br_resolved_q;
        br_taken_d    = br_taken_q;
        br_pc_d       = br_pc_q;
        if (!stall) begin
            if (wr && z_en) flag_z_d = new_z;
            if (wr && v_en) flag_v_d = new_v;
            if (wr && n_en) flag_n_d = new_n;
            br_resolved_d = br_acc;
            if (br_acc) begin
                br_taken_d = cond;
                br_pc_d    = cond ? br_target : pc_next;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_z_q      <= 1'b0;
            flag_v_q      <= 1'b0;
            flag_n_q      <= 1'b0;
            br_resolved_q <= 1'b0;
            br_taken_q    <= 1'b0;
            br_pc_q       <= '0;
        end else begin
            flag_z_q      <= flag_z_d;
            flag_v_q      <= flag_v_d;
            flag_n_q      <= flag_n_d;
            br_resolved_q <= br_resolved_d;
            br_taken_q    <= br_taken_d;
            br_pc_q       <= br_pc_d;
        end
    end

    assign flag_z      = flag_z_q;
    assign flag_v      = flag_v_q;
    assign flag_n      = flag_n_q;
    assign br_resolved = br_resolved_q;
    assign br_taken    = br_taken_q;
    assign br_pc       = br_pc_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Self-checking bench for flag_branch_unit: constant vector table, hand
// sequences for stall/reset corners, then random stimulus against a model.
module tb_flag_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, ex_valid, ex_ovfl, z_en, v_en, n_en, br_valid;
    logic [15:0] ex_result, br_target, pc_next;
    logic [2:0]  br_ccc;
    logic        flag_z, flag_v, flag_n, br_resolved, br_taken;
    logic [15:0] br_pc;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          mz, mv, mn, mres, mtk;
    logic [15:0] mpc;

    flag_branch_unit #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_result(ex_result), .ex_ovfl(ex_ovfl),
        .z_en(z_en), .v_en(v_en), .n_en(n_en),
        .br_valid(br_valid), .br_ccc(br_ccc), .br_target(br_target), .pc_next(pc_next),
        .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n),
        .br_resolved(br_resolved), .br_taken(br_taken), .br_pc(br_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, flush, exv;
        logic [15:0] res;
        logic        ovfl, ze, ve, ne, brv;
        logic [2:0]  ccc;
        logic [15:0] tgt, pcn;
        logic        ez, ev, en, eres, etk;
        logic [15:0] epc;
    } vec_t;

    vec_t vt[15];

    function automatic vec_t mkv(logic s, logic f, logic x, logic [15:0] r, logic o,
                                 logic a, logic b, logic c, logic bv, logic [2:0] cc,
                                 logic [15:0] t, logic [15:0] p,
                                 logic ez, logic ev, logic en, logic er, logic et,
                                 logic [15:0] ep);
        vec_t v;
        v.stall = s; v.flush = f; v.exv = x; v.res = r; v.ovfl = o;
        v.ze = a; v.ve = b; v.ne = c; v.brv = bv; v.ccc = cc; v.tgt = t; v.pcn = p;
        v.ez = ez; v.ev = ev; v.en = en; v.eres = er; v.etk = et; v.epc = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input bit ez, input bit ev, input bit en,
                           input bit er, input bit et, input logic [15:0] ep);
        chk({tag, ".flag_z"}, {15'd0, flag_z}, {15'd0, ez});
        chk({tag, ".flag_v"}, {15'd0, flag_v}, {15'd0, ev});
        chk({tag, ".flag_n"}, {15'd0, flag_n}, {15'd0, en});
        chk({tag, ".br_resolved"}, {15'd0, br_resolved}, {15'd0, er});
        chk({tag, ".br_taken"}, {15'd0, br_taken}, {15'd0, et});
        chk({tag, ".br_pc"}, br_pc, ep);
    endtask

    // Branch condition rules, written straight from the condition table
    function automatic bit cond_ok(logic [2:0] cc, bit z, bit v, bit n);
        case (cc)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    // Apply current inputs for one cycle, advance the model, compare
    task automatic step(input string tag);
        bit ez, ev, en, fire;
        if (!rst_n) begin
            mz = 0; mv = 0; mn = 0; mres = 0; mtk = 0; mpc = '0;
        end else if (!stall) begin
            bit live;
            live = ex_valid && !flush;
            ez = (live && z_en) ? (ex_result == 16'h0) : mz;
            ev = (live && v_en) ? ex_ovfl : mv;
            en = (live && n_en) ? ex_result[15] : mn;
            fire = br_valid && !flush;
            if (fire) begin
                mtk = cond_ok(br_ccc, ez, ev, en);
                mpc = mtk ? br_target : pc_next;
            end
            mres = fire;
            mz = ez; mv = ev; mn = en;
        end
        @(posedge clk);
        #1;
        chk_all(tag, mz, mv, mn, mres, mtk, mpc);
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; ex_valid = 0; ex_result = '0; ex_ovfl = 0;
        z_en = 0; v_en = 0; n_en = 0; br_valid = 0; br_ccc = '0;
        br_target = '0; pc_next = '0;
    endtask

    initial begin
        //         st fl ex res      ov z  v  n  bv ccc     tgt      pcn       ez ev en er et pc
        vt[0]  = mkv(0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000);
        vt[1]  = mkv(0, 0, 1, 16'h0000, 0, 1, 1, 1, 0, 3'd0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 16'h0000);
        vt[2]  = mkv(0, 0, 1, 16'h8001, 0, 1, 0, 0, 0, 3'd0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000);
        vt[3]  = mkv(0, 0, 1, 16'hFFF0, 0, 1, 1, 1, 1, 3'd3, 16'h0040, 16'h0012, 0, 0, 1, 1, 1, 16'h0040);
        vt[4]  = mkv(0, 0, 1, 16'h0000, 0, 1, 1, 1, 0, 3'd0, 16'h0000, 16'h0000, 1, 0, 0, 0, 1, 16'h0040);
        vt[5]  = mkv(0, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 3'd0, 16'h0100, 16'h0022, 1, 0, 0, 1, 0, 16'h0022);
        vt[6]  = mkv(0, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 3'd7, 16'h0200, 16'h0032, 1, 0, 0, 1, 1, 16'h0200);
        vt[7]  = mkv(0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 16'h0000, 1, 0, 0, 0, 1, 16'h0200);
        vt[8]  = mkv(0, 1, 1, 16'h0000, 1, 1, 1, 1, 1, 3'd1, 16'h0300, 16'h0042, 1, 0, 0, 0, 1, 16'h0200);
        vt[9]  = mkv(0, 0, 1, 16'h8000, 1, 1, 1, 1, 1, 3'd6, 16'h0400, 16'h0052, 0, 1, 1, 1, 1, 16'h0400);
        vt[10] = mkv(0, 0, 1, 16'h0000, 0, 1, 0, 0, 1, 3'd2, 16'h0500, 16'h0062, 1, 1, 1, 1, 0, 16'h0062);
        vt[11] = mkv(0, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 3'd5, 16'h0600, 16'h0072, 1, 1, 1, 1, 1, 16'h0600);
        vt[12] = mkv(0, 0, 1, 16'h0001, 0, 1, 0, 0, 1, 3'd4, 16'h0700, 16'h0082, 0, 1, 1, 1, 0, 16'h0082);
        vt[13] = mkv(0, 0, 0, 16'h0000, 0, 1, 0, 0, 1, 3'd1, 16'h0800, 16'h0092, 0, 1, 1, 1, 0, 16'h0092);
        vt[14] = mkv(0, 0, 1, 16'h0000, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 16'h0000, 0, 1, 1, 0, 0, 16'h0092);

        idle_inputs();
        rst_n = 0;
        step("reset0");
        step("reset1");
        rst_n = 1;
        step("idle");

        // Table-driven directed vectors
        for (int i = 0; i < 15; i++) begin
            stall = vt[i].stall; flush = vt[i].flush; ex_valid = vt[i].exv;
            ex_result = vt[i].res; ex_ovfl = vt[i].ovfl;
            z_en = vt[i].ze; v_en = vt[i].ve; n_en = vt[i].ne;
            br_valid = vt[i].brv; br_ccc = vt[i].ccc;
            br_target = vt[i].tgt; pc_next = vt[i].pcn;
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vt[i].ez, vt[i].ev, vt[i].en,
                    vt[i].eres, vt[i].etk, vt[i].epc);
        end

        // Resync model with a reset
        idle_inputs();
        rst_n = 0;
        step("resync");
        rst_n = 1;

        // Stall holding a resolved pulse and freezing flags
        br_valid = 1; br_ccc = 3'd7; br_target = 16'h0A00; pc_next = 16'h00A2;
        step("stall.accept");
        chk("stall.accept.pulse", {15'd0, br_resolved}, 16'd1);
        stall = 1; ex_valid = 1; z_en = 1; ex_result = 16'h0000;
        br_ccc = 3'd0; br_target = 16'h0B00; pc_next = 16'h00B2;
        for (int i = 0; i < 3; i++) begin
            step($sformatf("stall.hold%0d", i));
            chk($sformatf("stall.hold%0d.pulse", i), {15'd0, br_resolved}, 16'd1);
            chk($sformatf("stall.hold%0d.z", i), {15'd0, flag_z}, 16'd0);
        end
        idle_inputs();
        step("stall.release");
        chk("stall.release.pulse", {15'd0, br_resolved}, 16'd0);
        chk("stall.release.pc", br_pc, 16'h0A00);

        // Reset during a stalled pulse
        br_valid = 1; br_ccc = 3'd7; br_target = 16'h0C00; pc_next = 16'h00C2;
        ex_valid = 1; n_en = 1; ex_result = 16'h8000;
        step("rst.accept");
        stall = 1;
        step("rst.stall");
        rst_n = 0;
        step("rst.mid");
        chk("rst.mid.pc", br_pc, 16'h0000);
        rst_n = 1;
        idle_inputs();
        step("rst.after");

        // Randomized stimulus against the model
        for (int i = 0; i < 600; i++) begin
            rst_n     = ($urandom_range(0, 60) != 0);
            stall     = ($urandom_range(0, 4) == 0);
            flush     = ($urandom_range(0, 5) == 0);
            ex_valid  = $urandom_range(0, 1);
            ex_result = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            ex_ovfl   = $urandom_range(0, 1);
            z_en      = $urandom_range(0, 1);
            v_en      = $urandom_range(0, 1);
            n_en      = $urandom_range(0, 1);
            br_valid  = $urandom_range(0, 1);
            br_ccc    = 3'($urandom_range(0, 7));
            br_target = 16'($urandom);
            pc_next   = 16'($urandom);
            step($sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Sits directly downstream of the 16-bit adder/ALU in the execute stage.
- Derives Z/N from the ALU result and takes V from the adder overflow output.
- Holds the architectural flag register (Z, V, N) with a per-flag write enable.
- Resolves conditional branches (B/BR) against the flags, with same-cycle bypass of an in-flight flag write, and registers the redirect decision for the fetch stage.

Parameters:
- WIDTH, 16, datapath width of the ALU result, branch target and PC.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- stall  in  1  pipeline stall; freezes all internal state.
- flush  in  1  kills this cycle's flag write and branch request.
- ex_valid  in  1  execute-stage instruction is valid.
- ex_result  in  WIDTH  ALU result.
- ex_ovfl  in  1  overflow from the adder.
- z_en  in  1  instruction writes Z (ADD, SUB, XOR, SLL, SRA, ROR).
- v_en  in  1  instruction writes V (ADD, SUB).
- n_en  in  1  instruction writes N (ADD, SUB).
- br_valid  in  1  branch request this cycle.
- br_ccc  in  3  condition code.
- br_target  in  WIDTH  taken-path target.
- pc_next  in  WIDTH  fall-through PC (PC+2).
- flag_z  out  1  registered Z.
- flag_v  out  1  registered V.
- flag_n  out  1  registered N.
- br_resolved  out  1  one-cycle pulse: branch outcome valid.
- br_taken  out  1  resolved outcome.
- br_pc  out  WIDTH  resolved next PC: br_target if taken, else pc_next.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-low on rst_n.
- Reset values (rst_n=0 at a rising edge): flag_z=flag_v=flag_n=0, br_resolved=0, br_taken=0, br_pc=0. Reset overrides stall and flush.
- Flag sources:
  - new_z = (ex_result == 0).
  - new_n = ex_result[WIDTH-1].
  - new_v = ex_ovfl.
- Flag write condition: wr = ex_valid & ~flush & ~stall. Each flag register loads its new value only when wr and its own enable are 1; otherwise it holds.
- Flag latency: a write presented in cycle t is visible on flag_* in cycle t+1.
- Bypass: the effective flags eff_X = (ex_valid & X_en & ~flush) ? new_X : flag_X.
  - Bypass is per flag: e.g. XOR bypasses Z only; V and N come from the register.
- Condition evaluation on eff flags:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GE: Z=1 | (Z=0 & N=0)
  - 101 LE: N=1 | Z=1
  - 110 OV: V=1
  - 111 UN: always taken
- Branch resolution: when br_valid & ~flush & ~stall in cycle t, the following are registered at the edge ending t and valid in t+1:
  - br_resolved=1
  - br_taken = condition result
  - br_pc = taken ? br_target : pc_next
- br_resolved pulses for exactly one cycle per accepted request. In any cycle with no accepted request, br_resolved=0 next cycle; br_taken and br_pc hold their last values.
- Stall: every register holds, including br_resolved.
  - A pulse present when stall rises stays asserted until stall falls.
  - The consumer must qualify on ~stall.
  - br_valid and ex_valid inputs are ignored while stalled; upstream re-presents them.
- Flush (flush=1, stall=0):
  - No flag write.
  - The branch request is dropped; br_resolved=0 next cycle; br_taken and br_pc hold.
  - Flush with stall: stall wins (hold). Flush is re-applied by the controller.
- Simultaneous flag write and branch in the same cycle: the branch uses the bypassed (new) flags, and both register updates occur at the same edge.
- Reset mid-stall or mid-pulse: clears everything at the next edge.

Test Plan:
1. Reset then idle:
   - rst_n=0 for 2 cycles, then 1; no requests.
   - flags all 0, br_resolved=0, br_pc=0.
2. Flag write and latency:
   - SUB with ex_result=16'h0000, ex_ovfl=0, z/v/n_en=1.
   - Next cycle flag_z=1, flag_v=0, flag_n=0.
   - Then XOR with result 16'h8001, z_en=1 only: flag_z=0, flag_n unchanged at 0.
3. Bypass:
   - Same cycle: ADD with result 16'hFFF0 (n_en=1) and BR with ccc=011 (LT), br_target=16'h0040, pc_next=16'h0012.
   - Next cycle br_resolved=1, br_taken=1, br_pc=16'h0040; flag_n=1.
4. Not taken and unconditional:
   - flags Z=1, N=0; ccc=000 (NE) -> br_taken=0, br_pc=pc_next.
   - ccc=111 the following cycle -> br_taken=1, br_pc=br_target.
   - br_resolved high for exactly one cycle each.
5. Flush:
   - ADD with result 0 plus branch ccc=001, with flush=1.
   - Next cycle br_resolved=0, flags unchanged, br_pc unchanged.
6. Stall:
   - Accept a branch, then assert stall for 3 cycles while driving ex_valid with z_en=1.
   - br_resolved stays 1 and flags are frozen for all 3 cycles.
   - br_resolved drops to 0 one cycle after stall is released.
